// File: rtl/my_pkg.sv
// Shared widths and FSM state type for the instruction-cache refill engine.
package my_pkg;
    localparam int DATA_WIDTH = 128;
    localparam int S_ADDR     = 60;
    localparam int BUS_WIDTH  = 64;
    localparam int BUS_ADDR_W = 64;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} refill_state_t;
endpackage

// File: rtl/riscv_icache_refill.sv
// Refill engine: fetches one cache line as BEATS bus reads, returns it with a mem_ready pulse.
// Latency: mem_ready 2*BEATS+1 cycles after accept (1 cycle on a line-buffer hit), +1 per gnt/rvalid stall.
// Backpressure: bus_req held until gnt; dropping rden aborts after the outstanding beat. Option: RISCV_REFILL_LINE_BUF_EN.
module riscv_icache_refill
    import my_pkg::*;
(
    input  logic                  i_riscv_icache_refill_clk,
    input  logic                  i_riscv_icache_refill_rst,
    input  logic                  i_riscv_icache_refill_rden,
    input  logic [S_ADDR-1:0]     i_riscv_icache_refill_blk_addr,
    output logic                  o_riscv_icache_refill_mem_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_icache_refill_mem_data,
    output logic                  o_riscv_icache_refill_bus_req,
    output logic [BUS_ADDR_W-1:0] o_riscv_icache_refill_bus_addr,
    input  logic                  i_riscv_icache_refill_bus_gnt,
    input  logic                  i_riscv_icache_refill_bus_rvalid,
    input  logic [BUS_WIDTH-1:0]  i_riscv_icache_refill_bus_rdata
);
    localparam int BEATS      = DATA_WIDTH / BUS_WIDTH;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BYTES = BUS_WIDTH / 8;
    localparam int LINE_OFF   = $clog2(DATA_WIDTH / 8);

    refill_state_t         state_q;
    logic [S_ADDR-1:0]     addr_q;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  abort_q;
    logic                  rden_q;
    logic                  served_vld;
    logic [S_ADDR-1:0]     served_addr;
    logic [DATA_WIDTH-1:0] line_q;

    logic                  new_req;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] line_next;
`ifdef RISCV_REFILL_LINE_BUF_EN
    logic                  buf_vld;
    logic                  buf_hit;
`endif

    always_comb begin
        new_req   = i_riscv_icache_refill_rden &&
                    (!rden_q || !served_vld || (i_riscv_icache_refill_blk_addr != served_addr));
        last_beat = (beat_cnt == CNT_W'(BEATS - 1));
        line_next = line_q;
        line_next[int'(beat_cnt) * BUS_WIDTH +: BUS_WIDTH] = i_riscv_icache_refill_bus_rdata;
`ifdef RISCV_REFILL_LINE_BUF_EN
        // mem_data always holds the last completed line, so it doubles as the buffer data.
        buf_hit   = buf_vld && (i_riscv_icache_refill_blk_addr == served_addr);
`endif
    end

    always_ff @(posedge i_riscv_icache_refill_clk) begin
        if (i_riscv_icache_refill_rst) begin
            state_q                         <= IDLE;
            addr_q                          <= '0;
            beat_cnt                        <= '0;
            abort_q                         <= 1'b0;
            rden_q                          <= 1'b0;
            served_vld                      <= 1'b0;
            served_addr                     <= '0;
            line_q                          <= '0;
            o_riscv_icache_refill_mem_ready <= 1'b0;
            o_riscv_icache_refill_mem_data  <= '0;
            o_riscv_icache_refill_bus_req   <= 1'b0;
            o_riscv_icache_refill_bus_addr  <= '0;
`ifdef RISCV_REFILL_LINE_BUF_EN
            buf_vld                         <= 1'b0;
`endif
        end else begin
            rden_q <= i_riscv_icache_refill_rden;
            case (state_q)
                IDLE: begin
                    if (new_req) begin
                        addr_q   <= i_riscv_icache_refill_blk_addr;
                        beat_cnt <= '0;
                        abort_q  <= 1'b0;
`ifdef RISCV_REFILL_LINE_BUF_EN
                        if (buf_hit) begin
                            state_q                         <= DONE;
                            o_riscv_icache_refill_mem_ready <= 1'b1;
                        end else
`endif
                        begin
                            state_q                        <= REQ;
                            o_riscv_icache_refill_bus_req  <= 1'b1;
                            o_riscv_icache_refill_bus_addr <=
                                {i_riscv_icache_refill_blk_addr, {LINE_OFF{1'b0}}};
                        end
                    end
                end
                REQ: begin
                    if (!i_riscv_icache_refill_rden) begin
                        abort_q <= 1'b1;
`ifdef RISCV_REFILL_LINE_BUF_EN
                        buf_vld <= 1'b0;
`endif
                    end
                    if (i_riscv_icache_refill_bus_gnt) begin
                        o_riscv_icache_refill_bus_req <= 1'b0;
                        state_q                       <= DATA;
                    end
                end
                DATA: begin
                    if (i_riscv_icache_refill_bus_rvalid) begin
                        line_q <= line_next;
                        if (abort_q || !i_riscv_icache_refill_rden) begin
                            abort_q <= 1'b0;
                            state_q <= IDLE;
`ifdef RISCV_REFILL_LINE_BUF_EN
                            buf_vld <= 1'b0;
`endif
                        end else if (last_beat) begin
                            o_riscv_icache_refill_mem_data  <= line_next;
                            o_riscv_icache_refill_mem_ready <= 1'b1;
                            state_q                         <= DONE;
                        end else begin
                            beat_cnt                       <= beat_cnt + 1'b1;
                            o_riscv_icache_refill_bus_req  <= 1'b1;
                            o_riscv_icache_refill_bus_addr <=
                                o_riscv_icache_refill_bus_addr + BUS_ADDR_W'(BEAT_BYTES);
                            state_q                        <= REQ;
                        end
                    end else if (!i_riscv_icache_refill_rden) begin
                        abort_q <= 1'b1;
`ifdef RISCV_REFILL_LINE_BUF_EN
                        buf_vld <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    o_riscv_icache_refill_mem_ready <= 1'b0;
                    served_addr                     <= addr_q;
                    served_vld                      <= 1'b1;
`ifdef RISCV_REFILL_LINE_BUF_EN
                    buf_vld                         <= 1'b1;
`endif
                    state_q                         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_icache_refill.sv
// Randomized bench for riscv_icache_refill against a transaction-level line/latency model.
// Honours RISCV_REFILL_LINE_BUF_EN the same way as the design.
module tb_riscv_icache_refill;
    import my_pkg::*;

    localparam int BEATS      = DATA_WIDTH / BUS_WIDTH;
    localparam int BEAT_BYTES = BUS_WIDTH / 8;
    localparam int W          = DATA_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rden;
    logic [S_ADDR-1:0]     blk_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  bus_req;
    logic [BUS_ADDR_W-1:0] bus_addr;
    logic                  gnt;
    logic                  rvalid;
    logic [BUS_WIDTH-1:0]  rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [31:0] seed;

    // Reference model state: last returned line, and whether it may be served from the buffer.
    logic [DATA_WIDTH-1:0] exp_data;
    logic [S_ADDR-1:0]     last_addr;
    bit                    buf_ok;

    riscv_icache_refill dut (
        .i_riscv_icache_refill_clk        (clk),
        .i_riscv_icache_refill_rst        (rst),
        .i_riscv_icache_refill_rden       (rden),
        .i_riscv_icache_refill_blk_addr   (blk_addr),
        .o_riscv_icache_refill_mem_ready  (mem_ready),
        .o_riscv_icache_refill_mem_data   (mem_data),
        .o_riscv_icache_refill_bus_req    (bus_req),
        .o_riscv_icache_refill_bus_addr   (bus_addr),
        .i_riscv_icache_refill_bus_gnt    (gnt),
        .i_riscv_icache_refill_bus_rvalid (rvalid),
        .i_riscv_icache_refill_bus_rdata  (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BUS_WIDTH-1:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ seed, a[63:32] ^ ~a[31:0]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] line_of(input logic [S_ADDR-1:0] a);
        logic [DATA_WIDTH-1:0] l;
        l = '0;
        for (int b = 0; b < BEATS; b++)
            l[b * BUS_WIDTH +: BUS_WIDTH] = mem_word({a, 4'h0} + 64'(b * BEAT_BYTES));
        return l;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rdata = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        rden = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_req", W'(bus_req), W'(0));
            check("idle_ready", W'(mem_ready), W'(0));
        end
    endtask

    // One icache request; ab = beat during whose DATA phase rden is dropped, -1 for none.
    task automatic run_req(input logic [S_ADDR-1:0] a, input int g[BEATS], input int r[BEATS],
                           input int ab);
        logic [63:0] ba;
        int  stalls;
        bit  hit;
        bit  aborted;
        stalls  = 0;
        hit     = 1'b0;
        aborted = 1'b0;
`ifdef RISCV_REFILL_LINE_BUF_EN
        hit = buf_ok && (a == last_addr);
`endif
        rden     = 1'b1;
        blk_addr = a;
        cyc      = 0;
        tick();
        if (hit) begin
            check("hit_ready", W'(mem_ready), W'(1));
            check("hit_nobus", W'(bus_req), W'(0));
            check("hit_data", mem_data, exp_data);
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                ba = {a, 4'h0} + 64'(b * BEAT_BYTES);
                check("req_hi", W'(bus_req), W'(1));
                check("req_addr", W'(bus_addr), W'(ba));
                for (int i = 0; i < g[b]; i++) begin
                    tick();
                    check("req_hold", W'(bus_req), W'(1));
                    check("addr_hold", W'(bus_addr), W'(ba));
                    check("ready_lo", W'(mem_ready), W'(0));
                end
                gnt = 1'b1;
                tick();
                gnt = 1'b0;
                check("req_drop", W'(bus_req), W'(0));
                if (ab == b) rden = 1'b0;
                for (int i = 0; i < r[b]; i++) begin
                    tick();
                    check("data_noreq", W'(bus_req), W'(0));
                    check("ready_lo", W'(mem_ready), W'(0));
                end
                rvalid = 1'b1;
                rdata  = mem_word(ba);
                tick();
                rvalid = 1'b0;
                stalls += g[b] + r[b];
                if (ab == b) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (aborted) begin
                check("abort_ready", W'(mem_ready), W'(0));
                check("abort_data", mem_data, exp_data);
                for (int i = 0; i < 2; i++) begin
                    tick();
                    check("abort_noreq", W'(bus_req), W'(0));
                    check("abort_ready", W'(mem_ready), W'(0));
                end
                check("abort_data", mem_data, exp_data);
                buf_ok = 1'b0;
            end else begin
                exp_data = line_of(a);
                check("ready", W'(mem_ready), W'(1));
                check("data", mem_data, exp_data);
                check("latency", W'(cyc), W'(2 * BEATS + 1 + stalls));
            end
        end
        if (!aborted) begin
            last_addr = a;
            buf_ok    = 1'b1;
            tick();
            check("pulse_1cyc", W'(mem_ready), W'(0));
            check("data_held", mem_data, exp_data);
        end
    endtask

    initial begin
        int g [BEATS];
        int r [BEATS];
        logic [S_ADDR-1:0] pick [4];
        logic [S_ADDR-1:0] a;
        int ab;

        seed      = $urandom;
        rst       = 1'b1;
        rden      = 1'b0;
        blk_addr  = '0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        exp_data  = '0;
        last_addr = '0;
        buf_ok    = 1'b0;
        tick();
        tick();
        check("rst_ready", W'(mem_ready), W'(0));
        check("rst_req", W'(bus_req), W'(0));
        check("rst_addr", W'(bus_addr), W'(0));
        check("rst_data", mem_data, W'(0));
        rst = 1'b0;
        idle(1);

        // Immediate miss at 0x40.
        g = '{default: 0};
        r = '{default: 0};
        run_req(60'h40, g, r, -1);
        idle(1);

        // gnt delayed three cycles on beat 0.
        g[0] = 3;
        run_req(60'h80, g, r, -1);
        g[0] = 0;

        // rden held with the same address: no new refill; then switch address.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_noreq", W'(bus_req), W'(0));
            check("hold_ready", W'(mem_ready), W'(0));
        end
        run_req(60'h41, g, r, -1);
        idle(1);

        // Abort during beat 0 data phase.
        r[0] = 1;
        run_req(60'h55, g, r, 0);
        r[0] = 0;
        idle(1);

        // Refill then re-request the same line (buffer hit when the buffer is built in).
        run_req(60'h40, g, r, -1);
        idle(1);
        run_req(60'h40, g, r, -1);
        idle(1);

        // Reset in REQ, then a stray rvalid.
        rden     = 1'b1;
        blk_addr = 60'h99;
        tick();
        check("pre_rst_req", W'(bus_req), W'(1));
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        rden = 1'b0;
        check("midrst_req", W'(bus_req), W'(0));
        check("midrst_ready", W'(mem_ready), W'(0));
        check("midrst_data", mem_data, W'(0));
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        check("stray_req", W'(bus_req), W'(0));
        check("stray_ready", W'(mem_ready), W'(0));
        tick();
        check("stray_ready2", W'(mem_ready), W'(0));
        check("stray_data", mem_data, W'(0));
        exp_data = '0;
        buf_ok   = 1'b0;
        run_req(60'h40, g, r, -1);
        idle(1);

        // Randomized traffic over a small address set to exercise repeats and the top of memory.
        pick[0] = 60'h40;
        pick[1] = 60'h41;
        pick[2] = '1;
        pick[3] = 60'({$urandom, $urandom});
        for (int t = 0; t < 60; t++) begin
            a = pick[$urandom_range(0, 3)];
            for (int b = 0; b < BEATS; b++) begin
                g[b] = int'($urandom_range(0, 3));
                r[b] = int'($urandom_range(0, 3));
            end
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            run_req(a, g, r, ab);
            idle(int'($urandom_range(1, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
